// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg : shared state encoding and sizing helper for the seq_mult unit.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold values up to WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_sign_conv.sv
// ----------------------------------------------------------------------------
// mult_sign_conv : conditional two's-complement negate (magnitude / sign fix).
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult_sign_conv #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    always_comb begin
        o_val = i_val;
        if (i_neg) begin
            o_val = (~i_val) + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_mult.sv
// ----------------------------------------------------------------------------
// seq_mult : WIDTH-cycle shift-add multiplier, unsigned or two's-complement.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_width(WIDTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_result;

    assign w_accept  = start && (r_state != ST_RUN);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});

    mult_sign_conv #(.W(WIDTH)) u_mag_a (
        .i_val (a),
        .i_neg (signed_mode & a[WIDTH-1]),
        .o_val (w_mag_a)
    );

    mult_sign_conv #(.W(WIDTH)) u_mag_b (
        .i_val (b),
        .i_neg (signed_mode & b[WIDTH-1]),
        .o_val (w_mag_b)
    );

    // Final iteration's sum feeds the negator directly so the product lands on the RUN->DONE edge.
    mult_sign_conv #(.W(2*WIDTH)) u_neg_res (
        .i_val (w_acc_nxt),
        .i_neg (r_neg),
        .o_val (w_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier  <= w_mag_b;
            r_neg     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc     <= w_acc_nxt;
            r_mcand   <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier  <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt     <= r_cnt + CW'(1);
            if (w_last) begin
                r_product <= w_result;
            end
        end
    end

    assign ready   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign product = r_product;

endmodule

`default_nettype wire
